// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the buffered stream demultiplexer.
package stream_demux_pkg;

    // Width of the saturating bad-select counter.
    localparam int CNT_W = 8;

    // Per-channel occupancy: 0, 1 or 2 items.
    typedef logic [1:0] occ_t;

    // True when a select value addresses an existing channel.
    function automatic logic sel_in_range(input logic [15:0] sel, input int n);
        return (int'(sel) < n);
    endfunction

endpackage

// File: rtl/demux_skid_fifo.sv
// Two-entry channel buffer: head register drives the consumer, tail holds
// the second item. A push while full is ignored; the top never issues one.
module demux_skid_fifo
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output occ_t         occ,
    output logic [W-1:0] head
);

    occ_t         occ_reg;
    logic [W-1:0] head_reg;
    logic [W-1:0] tail_reg;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (occ_reg != 2'd2);
    assign do_pop  = pop && (occ_reg != 2'd0);

    // Occupancy and storage update; simultaneous push/pop at one item
    // replaces the head directly so the new item is visible next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg  <= 2'd0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case (occ_reg)
                2'd0: begin
                    if (do_push) begin
                        head_reg <= din;
                        occ_reg  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        head_reg <= din;
                    end else if (do_push) begin
                        tail_reg <= din;
                        occ_reg  <= 2'd2;
                    end else if (do_pop) begin
                        occ_reg  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (do_pop) begin
                        head_reg <= tail_reg;
                        occ_reg  <= 2'd1;
                    end
                end
                default: occ_reg <= 2'd0;
            endcase
        end
    end

    assign occ  = occ_reg;
    assign head = head_reg;

endmodule

// File: rtl/stream_demux_buffered.sv
// Valid/ready demultiplexer with a two-entry buffer per output channel.
// up_ready depends only on up_sel and registered occupancy, never on
// down_ready, so consumers cannot create a combinational loop upstream.
module stream_demux_buffered
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [W-1:0]       up_data,
    input  logic [SEL_W-1:0]   up_sel,
    output logic [N_OUT-1:0]   down_valid,
    input  logic [N_OUT-1:0]   down_ready,
    output logic [N_OUT*W-1:0] down_data,
    output logic [CNT_W-1:0]   bad_sel_cnt
);

    logic               in_range;
    logic               sel_full;
    logic [N_OUT-1:0]   full;
    logic [N_OUT-1:0]   push;
    logic [N_OUT-1:0]   pop;
    occ_t               occ  [N_OUT];
    logic [W-1:0]       head [N_OUT];
    logic [CNT_W-1:0]   bad_sel_cnt_reg;

    assign in_range = sel_in_range(16'(up_sel), N_OUT);

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
            assign push[gi]       = up_valid && in_range &&
                                    (up_sel == SEL_W'(gi)) && !full[gi];
            assign pop[gi]        = down_valid[gi] && down_ready[gi];
            assign full[gi]       = (occ[gi] == 2'd2);
            assign down_valid[gi] = (occ[gi] != 2'd0);
            assign down_data[gi*W +: W] = head[gi];

            demux_skid_fifo #(.W(W)) u_fifo (
                .clk  (clk),
                .rst  (rst),
                .push (push[gi]),
                .pop  (pop[gi]),
                .din  (up_data),
                .occ  (occ[gi]),
                .head (head[gi])
            );
        end
    endgenerate

    // Select the full flag of the addressed channel; out-of-range selects
    // never stall because the item is simply discarded.
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (16'(up_sel) == 16'(i)) begin
                sel_full = full[i];
            end
        end
        up_ready = in_range ? !sel_full : 1'b1;
    end

    // Count discarded out-of-range items, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_sel_cnt_reg <= '0;
        end else if (up_valid && !in_range && (bad_sel_cnt_reg != {CNT_W{1'b1}})) begin
            bad_sel_cnt_reg <= bad_sel_cnt_reg + 1'b1;
        end
    end

    assign bad_sel_cnt = bad_sel_cnt_reg;

endmodule

// File: tb/tb_stream_demux_buffered.sv
// Randomised and directed bench for stream_demux_buffered. A four-channel
// instance is compared against per-channel queues capped at two items; a
// three-channel instance receives only out-of-range selects.
module tb_stream_demux_buffered;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Four-channel instance
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [7:0]  up_data = '0;
    logic [1:0]  up_sel = '0;
    logic [3:0]  down_valid;
    logic [3:0]  down_ready = '0;
    logic [31:0] down_data;
    logic [7:0]  bad_sel_cnt;

    // Three-channel instance
    logic        u3_valid = 1'b0;
    logic        u3_ready;
    logic [7:0]  u3_data = '0;
    logic [1:0]  u3_sel = 2'd3;
    logic [2:0]  u3_down_valid;
    logic [2:0]  u3_down_ready = 3'b111;
    logic [23:0] u3_down_data;
    logic [7:0]  u3_bad;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q [4][$];
    int         exp_bad3 = 0;
    logic       acc;
    logic       obs_ready;

    always #5 clk = ~clk;

    stream_demux_buffered #(.N_OUT(4), .W(8)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .bad_sel_cnt(bad_sel_cnt)
    );

    stream_demux_buffered #(.N_OUT(3), .W(8)) dut3 (
        .clk(clk), .rst(rst),
        .up_valid(u3_valid), .up_ready(u3_ready), .up_data(u3_data), .up_sel(u3_sel),
        .down_valid(u3_down_valid), .down_ready(u3_down_ready), .down_data(u3_down_data),
        .bad_sel_cnt(u3_bad)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model,
    // then return just after the rising edge ready for new inputs.
    task automatic cycle();
        logic exp_ready;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("valid%0d", i), down_valid[i], q[i].size() != 0);
            if (q[i].size() != 0)
                check($sformatf("data%0d", i), down_data[i*8 +: 8], q[i][0]);
        end
        exp_ready = (q[up_sel].size() != 2);
        obs_ready = up_ready;
        check("up_ready", up_ready, exp_ready);
        check("u3_ready", u3_ready, 1);
        check("u3_valid", u3_down_valid, 0);
        check("u3_bad", u3_bad, exp_bad3);
        check("bad_sel", bad_sel_cnt, 0);
        for (int i = 0; i < 4; i++)
            if (q[i].size() != 0 && down_ready[i]) void'(q[i].pop_front());
        acc = up_valid && exp_ready;
        if (acc) q[up_sel].push_back(up_data);
        if (u3_valid && exp_bad3 < 255) exp_bad3++;
        @(posedge clk);
        #1;
    endtask

    // Offer one item until accepted; n returns the number of cycles taken.
    task automatic send(input int sel, input logic [7:0] d, output int n);
        up_valid = 1'b1;
        up_sel   = 2'(sel);
        up_data  = d;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n++;
            if (acc) break;
        end
        if (!acc) check("send_timeout", 0, 1);
        up_valid = 1'b0;
        $display("send ch=%0d data=%02h cycles=%0d", sel, d, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;

        // Reset state
        @(posedge clk); #1;
        check("rst_valid", down_valid, 0);
        check("rst_bad", bad_sel_cnt, 0);
        check("rst_ready", up_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single route
        down_ready = 4'b1111;
        send(2, 8'h5C, n);
        check("single_dv", down_valid, 4'b0100);
        check("single_data", down_data[23:16], 8'h5C);
        cycle();
        check("single_once", down_valid, 4'b0000);

        // Back-pressure on channel 0
        down_ready = 4'b1110;
        send(0, 8'h11, n);
        send(0, 8'h22, n);
        up_valid = 1'b1; up_sel = 2'd0; up_data = 8'h33;
        cycle(); check("bp_stall_a", obs_ready, 0);
        cycle(); check("bp_stall_b", obs_ready, 0);
        down_ready = 4'b1111;
        cycle(); check("bp_first_pop", obs_ready, 0);
        cycle(); check("bp_accept", obs_ready, 1);
        up_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        // Independence: channel 0 full and stalled, channel 3 unaffected
        down_ready = 4'b1110;
        send(0, 8'h55, n);
        send(0, 8'h66, n);
        send(3, 8'h44, n);
        check("indep_wait", n, 1);
        check("indep_dv3", down_valid[3], 1);
        down_ready = 4'b1111;
        for (int k = 0; k < 4; k++) cycle();

        // Throughput into channel 1
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            send(1, 8'(k), n);
            if (n != 1) stalls++;
        end
        check("thru_stalls", stalls, 0);
        for (int k = 0; k < 3; k++) cycle();

        // Out-of-range on the three-channel instance
        u3_valid = 1'b1; u3_sel = 2'd3;
        for (int k = 0; k < 300; k++) cycle();
        u3_valid = 1'b0;
        check("oor_sat", u3_bad, 255);

        // Reset mid-stream with channel 1 holding two items
        down_ready = 4'b0000;
        send(1, 8'hA1, n);
        send(1, 8'hA2, n);
        check("pre_rst_dv1", down_valid[1], 1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", down_valid, 0);
        check("rst_mid_data", down_data, 0);
        check("rst_mid_bad3", u3_bad, 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        exp_bad3 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        down_ready = 4'b1111;
        for (int k = 0; k < 3; k++) cycle();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            up_valid   = 1'($urandom_range(0, 1));
            up_sel     = 2'($urandom_range(0, 3));
            up_data    = 8'($urandom);
            down_ready = 4'($urandom);
            u3_valid   = 1'($urandom_range(0, 1));
            cycle();
            if (acc) $display("rand ch=%0d data=%02h", up_sel, up_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
